// File: rtl/ksa_mwadd.sv
// Multi-word adder: streams operand word pairs (LS word first) through a
// 16-bit Kogge-Stone adder, chaining the carry between words of an operation,
// with a one-entry output register, framing checks and a length limit.

// 16-bit radix-2 Kogge-Stone prefix adder, purely combinational.
module ksa_mwadd_ksa16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [15:0] g_init;
  logic [15:0] p_init;
  logic [15:0] g_pre;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      assign p_init[gi] = a[gi] ^ b[gi];
      // Fold the carry-in into bit 0 so every prefix G is a true carry-out.
      if (gi == 0) begin : g_lsb
        assign g_init[gi] = (a[gi] & b[gi]) | (p_init[gi] & ci);
        assign s[gi]      = p_init[gi] ^ ci;
      end else begin : g_upper
        assign g_init[gi] = a[gi] & b[gi];
        assign s[gi]      = p_init[gi] ^ g_pre[gi-1];
      end
    end
  endgenerate

  // Four prefix levels (span 1,2,4,8); descending bit order keeps each level
  // reading the previous level's values while updating in place.
  always_comb begin
    logic [15:0] g_v;
    logic [15:0] p_v;
    g_v = g_init;
    p_v = p_init;
    for (int lvl = 0; lvl < 4; lvl++) begin
      for (int i = 15; i >= (1 << lvl); i--) begin
        g_v[i] = g_v[i] | (p_v[i] & g_v[i - (1 << lvl)]);
        p_v[i] = p_v[i] & p_v[i - (1 << lvl)];
      end
    end
    g_pre = g_v;
  end

  assign co = g_pre[15];
endmodule

module ksa_mwadd #(
  parameter  int WMAX = 8,
  localparam int IW   = $clog2(WMAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_a,
  input  logic [15:0]   in_b,
  input  logic          in_first,
  input  logic          in_last,
  input  logic          in_ci,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_s,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_co,
  output logic          err_seq,
  output logic          err_len
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_s_q, out_s_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic          out_last_q, out_last_d;
  logic          out_co_q, out_co_d;
  logic          err_seq_q, err_seq_d;
  logic          err_len_q, err_len_d;

  logic          accept;
  logic          word_start;
  logic          word_ci;
  logic [IW-1:0] word_idx;
  logic          word_hit_len;
  logic          word_closes;
  logic [15:0]   word_s;
  logic          word_co;

  // One-entry output register: room whenever it is empty or being drained.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // A word starts a new operation when none is open or when it claims first.
  assign word_start   = (state_q == S_IDLE) | in_first;
  assign word_ci      = word_start ? in_ci : carry_q;
  assign word_idx     = word_start ? '0 : idx_q + IW'(1);
  assign word_hit_len = ~in_last & (word_idx == IW'(WMAX - 1));
  assign word_closes  = in_last | word_hit_len;

  ksa_mwadd_ksa16 u_ksa (
    .a  (in_a),
    .b  (in_b),
    .ci (word_ci),
    .s  (word_s),
    .co (word_co)
  );

  // Next-state: capture an accepted word, otherwise drain or hold the result.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_s_d     = out_s_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_co_d    = out_co_q;
    err_seq_d   = 1'b0;
    err_len_d   = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_s_d     = word_s;
      out_idx_d   = word_idx;
      out_last_d  = word_closes;
      out_co_d    = word_closes & word_co;
      carry_d     = word_co;
      idx_d       = word_idx;
      state_d     = word_closes ? S_IDLE : S_BUSY;
      err_seq_d   = (state_q == S_IDLE) ? ~in_first : in_first;
      err_len_d   = word_hit_len;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_co_q    <= 1'b0;
      err_seq_q   <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_co_q    <= out_co_d;
      err_seq_q   <= err_seq_d;
      err_len_q   <= err_len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_co    = out_co_q;
  assign err_seq   = err_seq_q;
  assign err_len   = err_len_q;
endmodule

// File: doc/ksa_mwadd.md
KSA_MWADD -- requirements
Module: ksa_mwadd

Interface
REQ-001 Parameter: WMAX, 8, maximum words per operand (2..16); a word index counter of ceil(log2(WMAX)) bits, IW, is derived from it.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  operand word pair offered.
REQ-005 Port: in_ready  output  1  block accepts the offered word this cycle.
REQ-006 Port: in_a  input  16  operand A word, least-significant word first.
REQ-007 Port: in_b  input  16  operand B word.
REQ-008 Port: in_first  input  1  word is word 0 of a new operation.
REQ-009 Port: in_last  input  1  word is the final word of the operation.
REQ-010 Port: in_ci  input  1  carry-in of the operation, sampled only with in_first.
REQ-011 Port: out_valid  output  1  result word held.
REQ-012 Port: out_ready  input  1  consumer accepts the result word.
REQ-013 Port: out_s  output  16  sum word.
REQ-014 Port: out_idx  output  IW  word index of out_s (0 = least significant).
REQ-015 Port: out_last  output  1  out_s is the final word.
REQ-016 Port: out_co  output  1  carry-out of the whole operation, meaningful only when out_last=1, else 0.
REQ-017 Port: err_seq  output  1  one-cycle pulse: framing error.
REQ-018 Port: err_len  output  1  one-cycle pulse: operation hit WMAX words without in_last.

Function
REQ-019 Word add: {co,s} = a + b + ci, computed by one 16-bit Kogge-Stone (radix-2) prefix adder instance, combinational within the cycle.
REQ-020 Accept: a word is accepted on a rising edge where in_valid=1 and in_ready=1; in_ready = !out_valid | out_ready (combinational, one-entry output register).
REQ-021 Latency: the result of a word accepted at edge k is on out_* from edge k through the edge where it is consumed; throughput is one word per cycle under continuous out_ready=1.
REQ-022 Output hold: while out_valid=1 and out_ready=0, out_s, out_idx, out_last, and out_co are stable.
REQ-023 State machine: IDLE (no operation open) and BUSY (operation open, carry_q and idx_q valid).
REQ-024 Carry select: ci = in_ci when the word starts an operation, else carry_q; carry_q <= word carry-out on every accept.
REQ-025 IDLE + accept with in_first=1: idx 0; go to BUSY, or stay IDLE if in_last=1.
REQ-026 IDLE + accept with in_first=0: treat the word as first (ci=in_ci, idx 0) and pulse err_seq.
REQ-027 BUSY + accept with in_first=0: idx = idx_q+1, ci = carry_q; in_last=1 returns to IDLE.
REQ-028 BUSY + accept with in_first=1: abandon the open operation, start a new one as in REQ-025, and pulse err_seq; no result is emitted for the abandoned tail.
REQ-029 Length limit: a non-last word accepted at idx = WMAX-1 is emitted with out_last=1 and out_co = its carry-out, err_len pulses, and the state returns to IDLE.
REQ-030 out_last=1 exactly for words closing an operation (REQ-025/027/029); out_co = carry-out of that word.
REQ-031 Error pulses are asserted in the cycle after the causing accept, for exactly one cycle.
REQ-032 Simultaneous output consume and input accept in one cycle is legal; the new word replaces the old with no bubble.

Reset
REQ-033 rst_n=0 forces immediately: state IDLE, carry_q 0, idx_q 0, out_valid 0, out_s 0, out_idx 0, out_last 0, out_co 0, err_seq 0, err_len 0; in_ready = 1 after reset.
REQ-034 Reset mid-operation discards the open operation and any held result; the first accept after release follows the IDLE rules.

Verification
REQ-035 Single word: a=FFFF b=0001 ci=1, first=last=1 -> next cycle out_s=0001 out_idx=0 out_last=1 out_co=1.
REQ-036 Two words, out_ready=1: (FFFF,0001,ci=0,first) then (0019,0000,last) -> out_s 0000 idx0, then 001A idx1 last=1 co=0; then (FFFF,0007,ci=1,first=last) -> 0007 co=1.
REQ-037 Backpressure: out_ready=0 for 3 cycles after the first result -> in_ready=0, out_* frozen; on release, the words stream in order with no loss or duplication.
REQ-038 Framing: in_first=1 at idx1 of an open 3-word op -> err_seq pulse, new op at idx0 with ci=in_ci; a non-first word while IDLE -> err_seq pulse, idx0.
REQ-039 Length: WMAX=8, 8 words FFFF+0000 with ci=1 and no last -> all out_s=0000, word 7 out_last=1 out_co=1, err_len pulse, state IDLE.
REQ-040 Reset: rst_n low asynchronously mid-operation with a result held -> out_valid=0 and all outputs 0 without a clock edge; next op computes correctly with ci=in_ci.
